clock_div_multi: RTL and testbench

Multi-channel programmable clock divider that generates NCH independent divided clocks and tick strobes from the 50 MHz system clock. It is the parametrised successor to the fixed 1 s divider. It adds per-channel runtime divisors loaded through a valid/ready port, a per-channel toggle or pulse mode, per-channel enables, and glitch-free divisor updates. Downstream timers, blinkers and scan logic consume either `clk_out` as a slow square wave or `tick` as a clock-enable.

---
 rtl/clock_div_multi.sv | 111 +++++++++++
 tb/tb_clock_div_multi.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider: per-channel divisor, toggle/pulse mode,
// enable and shadowed divisor updates. Optional global phase-align via CLKDIV_SYNC_EN.
module clock_div_multi #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 26,
    parameter int unsigned DEFAULT_DIV = 25000000,
    localparam int unsigned CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_50m,
    input  logic           reset,
    input  logic [NCH-1:0] ch_en,
    input  logic [NCH-1:0] mode,
    input  logic           cfg_valid,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic           cfg_ready,
    input  logic           sync,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick
);

    logic [CW-1:0]  r_cnt    [NCH];
    logic [CW-1:0]  r_div    [NCH];
    logic [CW-1:0]  r_shadow [NCH];
    logic [NCH-1:0] r_pend;
    logic [NCH-1:0] r_clk_out;
    logic [NCH-1:0] r_tick;

    logic           w_ch_ok;
    logic [CW-1:0]  w_div_clamped;
    logic [NCH-1:0] w_restart;
    logic [NCH-1:0] w_tc;
    logic [NCH-1:0] w_wr;

    assign w_ch_ok       = 32'(cfg_ch) < NCH;
    assign w_div_clamped = (cfg_div == '0) ? CW'(1) : cfg_div;

    // Out-of-range channel writes are accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        if (w_ch_ok) begin
            cfg_ready = ~r_pend[cfg_ch];
        end
    end

`ifdef CLKDIV_SYNC_EN
    assign w_restart = ~ch_en | {NCH{sync}};
`else
    logic w_unused_sync;
    assign w_unused_sync = sync;
    assign w_restart     = ~ch_en;
`endif

    always_comb begin
        w_tc = '0;
        w_wr = '0;
        for (int i = 0; i < NCH; i++) begin
            w_tc[i] = (r_cnt[i] == (r_div[i] - CW'(1)));
            w_wr[i] = cfg_valid & cfg_ready & w_ch_ok & (cfg_ch == CHW'(i));
        end
    end

    // Per-channel counter, divisor shadow and output registers.
    always_ff @(posedge clk_50m) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i]    <= '0;
                r_div[i]    <= CW'(DEFAULT_DIV);
                r_shadow[i] <= CW'(DEFAULT_DIV);
            end
            r_pend    <= '0;
            r_clk_out <= '0;
            r_tick    <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_restart[i]) begin
                    r_cnt[i]     <= '0;
                    r_clk_out[i] <= 1'b0;
                    r_tick[i]    <= 1'b0;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_shadow[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (w_tc[i]) begin
                    r_cnt[i]     <= '0;
                    r_tick[i]    <= 1'b1;
                    r_clk_out[i] <= mode[i] ? 1'b0 : ~r_clk_out[i];
                    if (r_pend[i]) begin
                        r_div[i]  <= r_shadow[i];
                        r_pend[i] <= 1'b0;
                    end
                end else begin
                    r_cnt[i]  <= r_cnt[i] + CW'(1);
                    r_tick[i] <= 1'b0;
                    if (mode[i]) begin
                        r_clk_out[i] <= 1'b0;
                    end
                end
                // A write needs pend low, so it never collides with a transfer.
                if (w_wr[i]) begin
                    r_shadow[i] <= w_div_clamped;
                    r_pend[i]   <= 1'b1;
                end
            end
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench for clock_div_multi: directed scenarios then random traffic,
// compared every cycle against a count-down reference model.
module tb_clock_div_multi;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DDIV = 4;

    logic           clk_50m = 1'b0;
    logic           reset;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] mode;
    logic           cfg_valid;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_ready;
    logic           sync;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int total = 0;
    int bad   = 0;

    // Reference: edges remaining until next terminal count, plus pending divisor.
    int m_rem [NCH];
    int m_dv  [NCH];
    int m_sh  [NCH];
    bit m_pd  [NCH];
    bit m_ck  [NCH];
    bit m_tk  [NCH];

    clock_div_multi #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DDIV)) dut (
        .clk_50m  (clk_50m),
        .reset    (reset),
        .ch_en    (ch_en),
        .mode     (mode),
        .cfg_valid(cfg_valid),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_rem[i] = DDIV; m_dv[i] = DDIV; m_sh[i] = DDIV;
            m_pd[i] = 0; m_ck[i] = 0; m_tk[i] = 0;
        end
    endtask

    task automatic m_restart(input int i);
        if (m_pd[i]) begin m_dv[i] = m_sh[i]; m_pd[i] = 0; end
        m_rem[i] = m_dv[i];
        m_ck[i] = 0;
        m_tk[i] = 0;
    endtask

    // One clock: check cfg_ready before the edge, advance model, check outputs after.
    task automatic step();
        bit exp_rdy, wr, do_sync;
        int wch, wd;
        #1;
        exp_rdy = !m_pd[cfg_ch];
        chk("cfg_ready", 32'(cfg_ready), 32'(exp_rdy));
        wr  = cfg_valid && exp_rdy;
        wch = int'(cfg_ch);
        wd  = (cfg_div == 0) ? 1 : int'(cfg_div);
        @(posedge clk_50m);
`ifdef CLKDIV_SYNC_EN
        do_sync = sync;
`else
        do_sync = 0;
`endif
        if (reset) begin
            m_reset();
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (do_sync || !ch_en[i]) begin
                    m_restart(i);
                end else if (m_rem[i] == 1) begin
                    m_tk[i] = 1;
                    m_ck[i] = mode[i] ? 0 : !m_ck[i];
                    if (m_pd[i]) begin m_dv[i] = m_sh[i]; m_pd[i] = 0; end
                    m_rem[i] = m_dv[i];
                end else begin
                    m_rem[i]--;
                    m_tk[i] = 0;
                    if (mode[i]) m_ck[i] = 0;
                end
            end
            if (wr) begin m_sh[wch] = wd; m_pd[wch] = 1; end
        end
        #1;
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("clk_out[%0d]", i), 32'(clk_out[i]), 32'(m_ck[i]));
            chk($sformatf("tick[%0d]", i), 32'(tick[i]), 32'(m_tk[i]));
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic write(input int ch, input int d);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = CW'(d);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ch_en = '0; mode = '0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0; sync = 1'b0;
        repeat (2) @(posedge clk_50m);
        m_reset();
        step();

        // Default divisor 4 in toggle mode on ch0
        reset = 1'b0; ch_en = 4'b0001;
        run(20);

        // Reset mid-period
        reset = 1'b1; step();
        reset = 1'b0; run(3);

        // Pulse mode on ch1 with D=3 written while disabled
        write(1, 3);
        ch_en = 4'b0011; mode = 4'b0010;
        run(12);

        // Glitch-free update of running ch0 to D=2
        write(0, 2);
        run(12);

        // D=0 clamps to 1, toggle then pulse
        write(3, 0);
        ch_en[3] = 1'b1; run(6);
        mode[3] = 1'b1;  run(4);

        // Disable / re-enable ch2 with D=5
        write(2, 5);
        ch_en[2] = 1'b1; run(7);
        ch_en[2] = 1'b0; step();
        ch_en[2] = 1'b1; run(12);

        // Sync strobe with ch0 D=3 and ch1 D=5
        write(0, 3); run(4);
        write(1, 5); run(8);
        sync = 1'b1; step();
        sync = 1'b0; run(10);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 31) == 0) mode  = 4'($urandom);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom);
            cfg_div   = CW'($urandom_range(0, 6));
            sync      = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
